multicycle_ctrl: RTL

Multicycle main controller for the 16-bit CPU core. It sequences fetch, decode, execute, memory and writeback, and drives every datapath enable. It generates `aluop` for the ALU decoder directly downstream and consumes that decoder's `halt` output. It waits on a memory-ready handshake and freezes the core on HALT until reset.

---
 rtl/multicycle_ctrl.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle main controller for the 16-bit CPU core.
// Sequences fetch / decode / execute / memory / writeback and drives every
// datapath enable. State and the Moore control word are held in registers;
// only the PC load, the IR load (both gated by the memory handshake or the
// branch decision) and the DECODE-time aluop are formed combinationally.
module multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op1,
    input  logic [2:0] op2,
    input  logic [2:0] cond,
    input  logic       flag_z,
    input  logic       flag_s,
    input  logic       flag_v,
    input  logic       halt,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       flagwrite,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_ALU_WB = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WB = 4'd6,
        S_MEM_WR = 4'd7,
        S_LI     = 4'd8,
        S_BRANCH = 4'd9,
        S_HALTED = 4'd10
    } state_t;

    // Control word that depends only on the state. Held in a register so the
    // datapath sees glitch-free strobes.
    typedef struct packed {
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       flagwrite;
        logic       halted;
    } ctrl_t;

    localparam state_t RESET_ST = state_t'(RESET_STATE);

    // Opcode field values
    localparam logic [1:0] OP1_LD  = 2'b00;
    localparam logic [1:0] OP1_ST  = 2'b01;
    localparam logic [1:0] OP1_IMM = 2'b10;
    localparam logic [1:0] OP1_ALU = 2'b11;
    localparam logic [2:0] OP2_LI  = 3'b000;
    localparam logic [2:0] OP2_B   = 3'b100;
    localparam logic [2:0] OP2_BC  = 3'b111;

    // ALU operation selects
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    // ALU B operand selects
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM8 = 2'b10;

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;
    logic   br_taken;

    // Moore control word for a given state; anything not set stays 0, which
    // also covers HALTED (only the halted flag) and illegal codes.
    function automatic ctrl_t moore_decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memread = 1'b1;
                c.iord    = 1'b0;
                c.alusrca = 1'b0;
                c.alusrcb = SRCB_ONE;
                c.aluop   = ALU_ADD;
            end
            S_DECODE: begin
                // aluop here depends on op1, which is only valid once the
                // IR has loaded; it is overlaid combinationally below.
                c.aluop = ALU_ADD;
            end
            S_EXEC_R: begin
                c.alusrca   = 1'b1;
                c.alusrcb   = SRCB_REG;
                c.aluop     = ALU_FUNC;
                c.flagwrite = 1'b1;
            end
            S_ALU_WB: begin
                // Keep the ALU function selected so the result stays stable
                // while it is written back.
                c.regwrite = 1'b1;
                c.regdst   = 1'b0;
                c.memtoreg = 1'b0;
                c.aluop    = ALU_FUNC;
            end
            S_ADDR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM8;
                c.aluop   = ALU_ADD;
            end
            S_MEM_RD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEM_WB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b0;
                c.memtoreg = 1'b1;
            end
            S_MEM_WR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            S_LI: begin
                // The datapath forces A to zero, so A + imm8 loads the constant.
                c.alusrca  = 1'b1;
                c.alusrcb  = SRCB_IMM8;
                c.aluop    = ALU_ADD;
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca = 1'b0;
                c.alusrcb = SRCB_IMM8;
                c.aluop   = ALU_ADD;
            end
            S_HALTED: begin
                c.halted = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Branch decision from the live flag register; an ALU op just before the
    // branch has already written its flags by the time BRANCH is reached.
    always_comb begin
        br_taken = 1'b0;
        if (op2 == OP2_B) begin
            br_taken = 1'b1;
        end else begin
            case (cond)
                3'b000:  br_taken = flag_z;
                3'b001:  br_taken = flag_s ^ flag_v;
                3'b010:  br_taken = flag_z | (flag_s ^ flag_v);
                3'b011:  br_taken = ~flag_z;
                default: br_taken = 1'b0;
            endcase
        end
    end

    // Next-state selection; memory states wait on mem_ready, HALTED is sticky.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op1)
                    OP1_ALU: state_d = halt ? S_HALTED : S_EXEC_R;
                    OP1_LD,
                    OP1_ST:  state_d = S_ADDR;
                    OP1_IMM: begin
                        if (op2 == OP2_LI)
                            state_d = S_LI;
                        else if (op2 == OP2_B || op2 == OP2_BC)
                            state_d = S_BRANCH;
                        else
                            state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_EXEC_R: state_d = S_ALU_WB;
            S_ALU_WB: state_d = S_FETCH;
            S_ADDR: begin
                if (op1 == OP1_LD)
                    state_d = S_MEM_RD;
                else if (op1 == OP1_ST)
                    state_d = S_MEM_WR;
                else
                    state_d = S_FETCH;
            end
            S_MEM_RD: state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB: state_d = S_FETCH;
            S_MEM_WR: state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_LI:     state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register and the registered Moore control word, both forced to
    // the FETCH values immediately on reset so no strobe lingers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET_ST;
            ctrl_q  <= moore_decode(RESET_ST);
        end else begin
            state_q <= state_d;
            ctrl_q  <= moore_decode(state_d);
        end
    end

    // Handshake-qualified loads; held off while reset is high so a pending
    // mem_ready cannot advance PC or IR during reset.
    always_comb begin
        pcen    = 1'b0;
        irwrite = 1'b0;
        if (!reset) begin
            if (state_q == S_FETCH) begin
                pcen    = mem_ready;
                irwrite = mem_ready;
            end else if (state_q == S_BRANCH) begin
                pcen    = br_taken;
            end
        end
    end

    // In DECODE the ALU decoder must see the function select for ALU-group
    // instructions so that its halt output is valid.
    always_comb begin
        aluop = ctrl_q.aluop;
        if (state_q == S_DECODE)
            aluop = (op1 == OP1_ALU) ? ALU_FUNC : ALU_ADD;
    end

    assign iord      = ctrl_q.iord;
    assign memread   = ctrl_q.memread;
    assign memwrite  = ctrl_q.memwrite;
    assign regwrite  = ctrl_q.regwrite;
    assign regdst    = ctrl_q.regdst;
    assign memtoreg  = ctrl_q.memtoreg;
    assign alusrca   = ctrl_q.alusrca;
    assign alusrcb   = ctrl_q.alusrcb;
    assign flagwrite = ctrl_q.flagwrite;
    assign halted    = ctrl_q.halted;
    assign state     = state_q;

endmodule
